lsu_mem_responder: RTL and testbench
====================================

Name: lsu_mem_responder

Overview:
- Load/store unit that executes the memory command the instruction decoder raises (dmem write-enable, load writeback select, funct3 size).
- Accepts one load or store request from the datapath at a time.
- Drives a word-organised memory port with a request/grant handshake, and returns aligned, sign- or zero-extended load data.
- Splits accesses that cross a word boundary into two word transactions and stalls the core until the access completes.

Parameters:
- ADDR_W, 32, byte-address width; memory word address is ADDR_W-2 bits.
- DATA_W, 32, datapath and memory word width; fixed at 32, other values unsupported.

Ports:
- i_clk  in  1  clock; all state changes on the rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_req  in  1  access request from the datapath.
- i_we  in  1  1 = store, 0 = load.
- i_funct3  in  3  access size and sign, per the RISC-V load/store funct3 encoding.
- i_addr  in  ADDR_W  byte address.
- i_wdata  in  32  store data, right-aligned.
- o_ready  out  1  high only in IDLE; a request is accepted when i_req && o_ready.
- o_done  out  1  one-cycle completion pulse.
- o_err  out  1  valid with o_done; high for an illegal funct3.
- o_rdata  out  32  extended load data, valid with o_done on loads.
- o_mem_req  out  1  memory request.
- o_mem_we  out  1  memory write.
- o_mem_addr  out  ADDR_W-2  word address.
- o_mem_wdata  out  32  lane-aligned write data.
- o_mem_bmask  out  4  byte-lane enables; bit n covers bits 8n+7:8n.
- i_mem_gnt  in  1  grant; the request completes in any cycle where o_mem_req && i_mem_gnt.
- i_mem_rvalid  in  1  read data valid, arrives one or more cycles after the grant.
- i_mem_rdata  in  32  read word.

Behaviour:
- Reset (i_reset low, asynchronous): state goes to IDLE.
  - All registered outputs are 0: o_done, o_err, o_rdata, o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_bmask.
  - o_ready is 1.
  - Reset mid-transaction abandons the access; o_mem_req drops immediately.
- Accept: in IDLE with i_req high, the unit latches i_we, i_funct3, i_addr and i_wdata. Inputs are ignored in all other states.
- Size decode from funct3:
  - 000 = byte, signed (LB/SB); 100 = byte, unsigned (LBU).
  - 001 = half, signed (LH/SH); 101 = half, unsigned (LHU).
  - 010 = word (LW/SW).
  - Stores use only 000, 001 and 010.
  - Any other code is illegal: IDLE goes to RESP with o_err=1 and no memory request is made.
- Byte offset and split:
  - off = addr[1:0]; bytes = 1, 2 or 4.
  - The access is split when off+bytes > 4.
  - Word A = addr[ADDR_W-1:2]. Word B = A+1, wrapping modulo 2^(ADDR_W-2); the top word wraps to word 0.
- Store lanes:
  - 64-bit data = wdata << 8*off; 8-bit mask = ((1<<bytes)-1) << off.
  - Access A uses the low 32 bits of the data and the low 4 mask bits; access B uses the high halves.
- Load assembly:
  - Access A's rdata fills the low 32 bits of a 64-bit buffer, access B's rdata the high 32 bits.
  - Result = buffer >> 8*off, truncated to the size, then sign- or zero-extended per funct3.
  - Load bmask equals the store mask for that access.
- FSM states: IDLE, ISSUE0, WAIT0, ISSUE1, WAIT1, RESP.
  - IDLE -> ISSUE0 on accept with a legal funct3; IDLE -> RESP on accept with an illegal funct3.
  - ISSUE0: o_mem_req=1 with A's signals held stable until grant.
    - On grant, a load goes to WAIT0.
    - On grant, a store goes to ISSUE1 if split, otherwise to RESP.
  - WAIT0: on i_mem_rvalid, capture the low word, then go to ISSUE1 if split, otherwise to RESP.
  - ISSUE1 and WAIT1 behave the same way for access B; both end in RESP.
  - RESP: o_done=1 for one cycle, then IDLE.
- Timing: o_mem_req deasserts in the cycle after the grant. i_mem_rvalid is ignored outside WAIT0 and WAIT1, so stale data after a reset is dropped.
- Latency, measured from the accept edge with grant in the first cycle and rvalid one cycle after grant:
  - Aligned store: o_done at cycle 2.
  - Aligned load: o_done at cycle 3.
  - Split store: o_done at cycle 3.
  - Split load: o_done at cycle 5.
- Back-to-back requests: the next accept is possible the cycle after RESP.

Test Plan:
- Aligned SW: addr 0x100, wdata 0xDEADBEEF, gnt held high -> one request with o_mem_addr 0x40, bmask 1111, wdata 0xDEADBEEF; o_done at cycle 2, o_err 0.
- LB sign extension: addr 0x203, memory word 0x80112233 -> bmask 1000; o_rdata 0xFFFFFF80. Repeat as LBU -> o_rdata 0x00000080.
- Split LW: addr 0x0000_0006, word1 0x44332211, word2 0x88776655 -> two requests, addr 0x1 then 0x2, bmasks 1100 then 0011; o_rdata 0x66554433; o_done at cycle 5.
- Split SH with wrap: addr 0xFFFF_FFFF, wdata 0x0000ABCD -> request at word 0x3FFF_FFFF with bmask 1000 and wdata 0xCD000000, then word 0x0 with bmask 0001 and wdata 0x000000AB.
- Stalled grant plus illegal code:
  - Grant held low 3 cycles -> o_mem_req and address stay stable; o_ready stays 0.
  - funct3 011 -> o_done with o_err 1 at cycle 1 and no o_mem_req.
- Reset mid-load: assert i_reset low while in WAIT0 -> o_mem_req 0 and state IDLE immediately; a later i_mem_rvalid pulse produces no o_done.

Source files
------------

// File: rtl/lsu_mem_responder.sv
// lsu_mem_responder: load/store unit driving a word memory port, splitting misaligned accesses into two words
module lsu_mem_responder #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req,
  input  logic              i_we,
  input  logic [2:0]        i_funct3,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              o_ready,
  output logic              o_done,
  output logic              o_err,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-3:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic [3:0]        o_mem_bmask,
  input  logic              i_mem_gnt,
  input  logic              i_mem_rvalid,
  input  logic [DATA_W-1:0] i_mem_rdata
);
  typedef enum logic [2:0] {IDLE, ISSUE0, WAIT0, ISSUE1, WAIT1, RESP} state_t;
  state_t state, state_nx;
  logic              we;
  logic [2:0]        f3;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [63:0]       rbuf;
  logic [1:0]        off;
  logic [2:0]        bytes;
  logic              legal, split, second;
  logic [7:0]        mask;
  logic [63:0]       sdata;
  logic [31:0]       sh, ext;
  logic [ADDR_W-3:0] word_a, word_b;
  // stores accept only SB/SH/SW; loads additionally LBU/LHU
  function automatic logic legal_f(input logic w, input logic [2:0] f);
    return w ? (f == 3'b000 || f == 3'b001 || f == 3'b010) : (f[1:0] != 2'b11 && f != 3'b110);
  endfunction
  always_comb begin
    off    = addr[1:0];
    bytes  = f3[1] ? 3'd4 : f3[0] ? 3'd2 : 3'd1;
    legal  = legal_f(we, f3);
    split  = ({1'b0, off} + bytes) > 3'd4;
    mask   = (f3[1] ? 8'h0F : f3[0] ? 8'h03 : 8'h01) << off;
    sdata  = {32'b0, wdata} << {off, 3'b000};
    word_a = addr[ADDR_W-1:2];
    word_b = word_a + 1'b1;
    sh     = rbuf[{off, 3'b000} +: 32];
    ext    = f3[1] ? sh :
             f3[0] ? {{16{~f3[2] & sh[15]}}, sh[15:0]} :
                     {{24{~f3[2] & sh[7]}}, sh[7:0]};
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = i_req ? (legal_f(i_we, i_funct3) ? ISSUE0 : RESP) : IDLE;
      ISSUE0:  state_nx = !i_mem_gnt ? ISSUE0 : !we ? WAIT0 : split ? ISSUE1 : RESP;
      WAIT0:   state_nx = !i_mem_rvalid ? WAIT0 : split ? ISSUE1 : RESP;
      ISSUE1:  state_nx = !i_mem_gnt ? ISSUE1 : we ? RESP : WAIT1;
      WAIT1:   state_nx = i_mem_rvalid ? RESP : WAIT1;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    second      = state == ISSUE1;
    o_ready     = state == IDLE;
    o_done      = state == RESP;
    o_err       = o_done && !legal;
    o_rdata     = o_done && legal && !we ? ext : '0;
    o_mem_req   = state == ISSUE0 || second;
    o_mem_we    = o_mem_req && we;
    o_mem_addr  = !o_mem_req ? '0 : second ? word_b : word_a;
    o_mem_wdata = !o_mem_we ? '0 : second ? sdata[63:32] : sdata[31:0];
    o_mem_bmask = !o_mem_req ? '0 : second ? mask[7:4] : mask[3:0];
  end
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state <= IDLE;
      we    <= 1'b0;
      f3    <= '0;
      addr  <= '0;
      wdata <= '0;
      rbuf  <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && i_req) begin
        we    <= i_we;
        f3    <= i_funct3;
        addr  <= i_addr;
        wdata <= i_wdata;
      end
      if (state == WAIT0 && i_mem_rvalid) rbuf[31:0] <= i_mem_rdata;
      if (state == WAIT1 && i_mem_rvalid) rbuf[63:32] <= i_mem_rdata;
    end
  end
endmodule

// File: tb/tb_lsu_mem_responder.sv
// tb_lsu_mem_responder: randomized bench with a byte-level memory model and per-access latency prediction
module tb_lsu_mem_responder;
  logic        i_clk = 0, i_reset = 0, i_req = 0, i_we = 0;
  logic [2:0]  i_funct3 = 0;
  logic [31:0] i_addr = 0, i_wdata = 0, i_mem_rdata = 0;
  logic        i_mem_gnt = 0, i_mem_rvalid = 0;
  logic        o_ready, o_done, o_err, o_mem_req, o_mem_we;
  logic [31:0] o_rdata, o_mem_wdata;
  logic [29:0] o_mem_addr;
  logic [3:0]  o_mem_bmask;
  int n_vec = 0, n_err = 0;
  logic [31:0] mem [logic [29:0]];
  logic [31:0] rd;
  int lat;
  lsu_mem_responder dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_req(i_req), .i_we(i_we), .i_funct3(i_funct3),
    .i_addr(i_addr), .i_wdata(i_wdata), .o_ready(o_ready), .o_done(o_done), .o_err(o_err),
    .o_rdata(o_rdata), .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_mem_bmask(o_mem_bmask), .i_mem_gnt(i_mem_gnt),
    .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata)
  );
  always #5 i_clk = ~i_clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] rdw(input logic [29:0] w);
    return mem.exists(w) ? mem[w] : {w[13:0], 2'b10, ~w[15:0]};
  endfunction
  function automatic logic [7:0] rdb(input logic [31:0] a);
    logic [31:0] w;
    w = rdw(a[31:2]);
    return w[8*a[1:0] +: 8];
  endfunction
  task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                        input int smin, input int smax, input int rmax,
                        output logic [31:0] rdo, output int lato);
    logic legal, split, pend, done, gr;
    int nb, ntx, elat, t, stall, rvc;
    int st[2], rv[2];
    logic [63:0] d64;
    logic [7:0] m8;
    logic [3:0] m;
    logic [31:0] bm, erd;
    logic [29:0] wa[2];
    logic [29:0] rvw;
    legal = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    nb    = f3[1:0] == 2'd0 ? 1 : f3[1:0] == 2'd1 ? 2 : 4;
    split = int'(a[1:0]) + nb > 4;
    ntx   = !legal ? 0 : split ? 2 : 1;
    d64   = 64'(wd) << (8 * a[1:0]);
    m8    = 8'((1 << nb) - 1) << a[1:0];
    wa[0] = a[31:2];
    wa[1] = a[31:2] + 30'd1;
    erd = 0;
    for (int i = 0; i < nb; i++) erd[8*i +: 8] = rdb(a + 32'(i));
    if (nb < 4 && !f3[2] && erd[8*nb-1]) for (int i = 8*nb; i < 32; i++) erd[i] = 1'b1;
    elat = 1;
    for (int k = 0; k < ntx; k++) begin
      st[k] = $urandom_range(smin, smax);
      rv[k] = $urandom_range(0, rmax);
      elat += 1 + st[k] + (we ? 0 : 1 + rv[k]);
    end
    t = 0; stall = ntx > 0 ? st[0] : 0; pend = 0; done = 0; rvc = 0; rvw = 0; rdo = 0; lato = 0;
    @(negedge i_clk);
    chk("ready_idle", o_ready, 1);
    i_req = 1; i_we = we; i_funct3 = f3; i_addr = a; i_wdata = wd;
    for (int n = 1; n <= 100 && !done; n++) begin
      @(negedge i_clk);
      if (o_done) begin
        done = 1; lato = n; rdo = o_rdata;
        chk("err", o_err, !legal);
        chk("latency", n, elat);
        chk("txn_count", t, ntx);
        if (legal && !we) chk("rdata", o_rdata, erd);
        i_req = 0; i_mem_gnt = 0; i_mem_rvalid = 0;
      end else begin
        chk("ready_busy", o_ready, 0);
        i_mem_gnt = 1'($urandom_range(0, 1));
        gr = 0;
        if (o_mem_req) begin
          chk("req_expected", t < ntx, 1);
          i_mem_gnt = 0;
          if (t < ntx) begin
            m = t == 1 ? m8[7:4] : m8[3:0];
            chk("mem_addr", o_mem_addr, wa[t]);
            chk("mem_we", o_mem_we, we);
            chk("bmask", m, o_mem_bmask);
            if (we) chk("mem_wdata", o_mem_wdata, t == 1 ? d64[63:32] : d64[31:0]);
            if (stall > 0) stall--;
            else begin
              i_mem_gnt = 1; gr = 1;
              if (we) begin
                bm = {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
                mem[wa[t]] = (rdw(wa[t]) & ~bm) | ((t == 1 ? d64[63:32] : d64[31:0]) & bm);
              end else begin
                pend = 1; rvc = rv[t]; rvw = wa[t];
              end
              t++;
              stall = t < ntx ? st[t] : 0;
            end
          end
        end
        if (pend && !gr) begin
          if (rvc == 0) begin
            i_mem_rvalid = 1; i_mem_rdata = rdw(rvw); pend = 0;
          end else begin
            rvc--; i_mem_rvalid = 0; i_mem_rdata = $urandom;
          end
        end else begin
          i_mem_rvalid = gr ? 1'b0 : ($urandom_range(0, 3) == 0);
          i_mem_rdata = $urandom;
        end
        i_req = 1'($urandom_range(0, 1)); i_we = 1'($urandom_range(0, 1));
        i_funct3 = 3'($urandom); i_addr = $urandom; i_wdata = $urandom;
      end
    end
    if (!done) begin
      chk("timeout", 0, 1);
      i_req = 0; i_reset = 0;
      @(negedge i_clk);
      i_reset = 1;
    end else begin
      @(negedge i_clk);
      chk("done_pulse", o_done, 0);
      chk("ready_after", o_ready, 1);
    end
  endtask
  initial begin
    repeat (2) @(negedge i_clk);
    chk("rst_ready", o_ready, 1);
    chk("rst_done", o_done, 0);
    chk("rst_err", o_err, 0);
    chk("rst_rdata", o_rdata, 0);
    chk("rst_mem_req", o_mem_req, 0);
    chk("rst_mem_we", o_mem_we, 0);
    chk("rst_mem_addr", o_mem_addr, 0);
    chk("rst_mem_wdata", o_mem_wdata, 0);
    chk("rst_mem_bmask", o_mem_bmask, 0);
    i_reset = 1;
    access(1, 3'd2, 32'h100, 32'hDEADBEEF, 0, 0, 0, rd, lat);
    chk("sw_latency", lat, 2);
    chk("sw_mem", mem[30'h40], 32'hDEADBEEF);
    mem[30'h80] = 32'h80112233;
    access(0, 3'd0, 32'h203, 0, 0, 0, 0, rd, lat);
    chk("lb_rdata", rd, 32'hFFFFFF80);
    access(0, 3'd4, 32'h203, 0, 0, 0, 0, rd, lat);
    chk("lbu_rdata", rd, 32'h00000080);
    mem[30'h1] = 32'h44332211;
    mem[30'h2] = 32'h88776655;
    access(0, 3'd2, 32'h6, 0, 0, 0, 0, rd, lat);
    chk("split_lw_rdata", rd, 32'h66554433);
    chk("split_lw_latency", lat, 5);
    access(1, 3'd1, 32'hFFFFFFFF, 32'h0000ABCD, 0, 0, 0, rd, lat);
    chk("wrap_sh_hi", mem[30'h3FFFFFFF] >> 24, 32'hCD);
    chk("wrap_sh_lo", mem[30'h0] & 32'hFF, 32'hAB);
    access(1, 3'd2, 32'h44, 32'h12345678, 3, 3, 0, rd, lat);
    chk("stall_latency", lat, 5);
    access(0, 3'd3, 32'h10, 0, 0, 0, 0, rd, lat);
    chk("illegal_latency", lat, 1);
    // abandon a request still waiting for grant
    @(negedge i_clk);
    i_req = 1; i_we = 0; i_funct3 = 3'd2; i_addr = 32'h100;
    @(negedge i_clk);
    i_req = 0;
    chk("issue_req", o_mem_req, 1);
    i_reset = 0;
    #1;
    chk("rst_issue_req", o_mem_req, 0);
    chk("rst_issue_ready", o_ready, 1);
    chk("rst_issue_addr", o_mem_addr, 0);
    @(negedge i_clk);
    i_reset = 1;
    // abandon a load waiting for data, then feed stale rvalid
    @(negedge i_clk);
    i_req = 1;
    @(negedge i_clk);
    i_req = 0; i_mem_gnt = 1;
    @(negedge i_clk);
    i_mem_gnt = 0;
    chk("wait0_ready", o_ready, 0);
    i_reset = 0;
    #1;
    chk("rst_wait_ready", o_ready, 1);
    chk("rst_wait_req", o_mem_req, 0);
    @(negedge i_clk);
    i_reset = 1; i_mem_rvalid = 1; i_mem_rdata = 32'hCAFEF00D;
    @(negedge i_clk);
    i_mem_rvalid = 0;
    for (int k = 0; k < 4; k++) begin
      chk("stale_rvalid_done", o_done, 0);
      @(negedge i_clk);
    end
    for (int k = 0; k < 300; k++) begin
      logic [31:0] a;
      a = $urandom_range(0, 3) == 0 ? (32'hFFFFFFF0 | 32'($urandom_range(0, 15))) : 32'($urandom_range(0, 255));
      access(1'($urandom_range(0, 1)), 3'($urandom), a, $urandom, 0, 2, 2, rd, lat);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
